// File: rtl/mem_bus_responder.sv
// mem_bus_responder: page-selected burst memory responder on a multiplexed address/data bus
module mem_bus_responder #(
    parameter int          BUSWIDTH  = 16,
    parameter int          DATAWIDTH = 16,
    parameter int          BURST_LEN = 4,
    parameter logic [3:0]  PAGE_ID   = 4'h0,
    parameter int          MEM_DEPTH = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                rw,
    input  logic [BUSWIDTH-1:0] ad_in,
    output logic [BUSWIDTH-1:0] ad_out,
    output logic                ad_oe,
    output logic                busy,
    output logic                burst_done
);
    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;
    localparam logic [2:0] LAST = 3'(BURST_LEN - 1);
    state_t                state, state_n;
    logic [2:0]            beat, beat_n;
    logic [11:0]           ptr, ptr_n, rd_addr;
    logic [BUSWIDTH-1:0]   ad_out_n;
    logic                  ad_oe_n, busy_n, done_n, hit, last;
    logic [DATAWIDTH-1:0]  mem [MEM_DEPTH];
    logic [DATAWIDTH-1:0]  rd_data;
    // Reads look one word ahead so ad_out is registered with one cycle of latency
    assign rd_addr = (state == IDLE) ? ad_in[11:0] : ptr + 12'd1;
    assign rd_data = mem[rd_addr];
    assign hit     = start && (ad_in[BUSWIDTH-1 -: 4] == PAGE_ID);
    assign last    = beat == LAST;
    always_comb begin
        state_n  = state;
        beat_n   = beat;
        ptr_n    = ptr;
        ad_out_n = ad_out;
        ad_oe_n  = ad_oe;
        busy_n   = busy;
        done_n   = 1'b0;
        case (state)
            IDLE: if (hit) begin
                state_n = rw ? RD_BURST : WR_BURST;
                ptr_n   = ad_in[11:0];
                beat_n  = 3'd0;
                busy_n  = 1'b1;
                if (rw) begin
                    ad_out_n = rd_data;
                    ad_oe_n  = 1'b1;
                end
            end
            WR_BURST: begin
                ptr_n  = ptr + 12'd1;
                beat_n = beat + 3'd1;
                if (last) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            RD_BURST: begin
                ptr_n    = ptr + 12'd1;
                beat_n   = beat + 3'd1;
                ad_out_n = last ? '0 : rd_data;
                if (last) begin
                    ad_oe_n = 1'b0;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            beat       <= 3'd0;
            ptr        <= 12'd0;
            ad_out     <= '0;
            ad_oe      <= 1'b0;
            busy       <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            state      <= state_n;
            beat       <= beat_n;
            ptr        <= ptr_n;
            ad_out     <= ad_out_n;
            ad_oe      <= ad_oe_n;
            busy       <= busy_n;
            burst_done <= done_n;
        end
    end
    // Memory survives reset; a reset mid-burst only blocks the beat it coincides with
    always_ff @(posedge clk)
        if (!reset && state == WR_BURST)
            mem[ptr] <= ad_in;
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed and randomised burst checks against a bench-side memory model
module tb_mem_bus_responder;
    logic        clk, reset, start, rw;
    logic [15:0] ad_in, ad_out;
    logic        ad_oe, busy, burst_done;
    int          checks = 0, errors = 0;
    logic [15:0] model [4096];
    bit          known [4096];
    logic [15:0] wr_addrs [$];

    mem_bus_responder dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .ad_in(ad_in),
        .ad_out(ad_out), .ad_oe(ad_oe), .busy(busy), .burst_done(burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_burst(input logic [15:0] addr, input logic [3:0][15:0] d);
        logic [11:0] a;
        start = 1'b1; rw = 1'b0; ad_in = addr;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("wr_busy", {15'd0, busy}, 16'd1);
            check("wr_oe", {15'd0, ad_oe}, 16'd0);
            check("wr_done_early", {15'd0, burst_done}, 16'd0);
            ad_in = d[k];
            tick();
            a = addr[11:0] + 12'(k);
            model[a] = d[k];
            known[a] = 1'b1;
        end
        check("wr_done", {15'd0, burst_done}, 16'd1);
        check("wr_busy_end", {15'd0, busy}, 16'd0);
        wr_addrs.push_back(addr);
    endtask

    task automatic rd_burst(input logic [15:0] addr, input bit poke);
        logic [11:0] a;
        start = 1'b1; rw = 1'b1; ad_in = addr;
        tick();
        start = 1'b0; ad_in = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            a = addr[11:0] + 12'(k);
            check("rd_oe", {15'd0, ad_oe}, 16'd1);
            check("rd_busy", {15'd0, busy}, 16'd1);
            check("rd_done_early", {15'd0, burst_done}, 16'd0);
            if (known[a]) check("rd_data", ad_out, model[a]);
            if (poke && k == 1) begin
                start = 1'b1; rw = 1'b0; ad_in = 16'h0500;
            end else begin
                start = 1'b0; ad_in = 16'h0000;
            end
            tick();
        end
        start = 1'b0;
        check("rd_oe_end", {15'd0, ad_oe}, 16'd0);
        check("rd_out_end", ad_out, 16'h0000);
        check("rd_done", {15'd0, burst_done}, 16'd1);
        check("rd_busy_end", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        logic [3:0][15:0] d;
        logic [15:0] addr;
        start = 1'b0; rw = 1'b0; ad_in = 16'h0000; reset = 1'b1;
        for (int i = 0; i < 4096; i++) known[i] = 1'b0;
        tick(); tick();
        check("rst_ad_out", ad_out, 16'h0000);
        check("rst_ad_oe", {15'd0, ad_oe}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_done", {15'd0, burst_done}, 16'd0);
        reset = 1'b0;

        d = {16'hA004, 16'hA003, 16'hA002, 16'hA001};
        wr_burst(16'h0100, d);
        rd_burst(16'h0100, 1'b0);
        tick();

        d = {16'hB004, 16'hB003, 16'hB002, 16'hB001};
        wr_burst(16'h0FFE, d);
        rd_burst(16'h0FFE, 1'b0);
        rd_burst(16'h0000, 1'b0);
        check("wrap_000", model[0], 16'hB003);
        tick();

        // Foreign page: nothing should react, including the data-phase words
        start = 1'b1; rw = 1'b0; ad_in = 16'h3100;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ad_in = 16'hDEAD;
            check("page_busy", {15'd0, busy}, 16'd0);
            check("page_oe", {15'd0, ad_oe}, 16'd0);
            tick();
        end
        start = 1'b1; rw = 1'b1; ad_in = 16'h3100;
        tick();
        start = 1'b0;
        check("page_rd_oe", {15'd0, ad_oe}, 16'd0);
        check("page_rd_busy", {15'd0, busy}, 16'd0);
        rd_burst(16'h0100, 1'b0);
        tick();

        d = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        wr_burst(16'h0200, d);
        tick();
        start = 1'b1; rw = 1'b0; ad_in = 16'h0200;
        tick();
        start = 1'b0;
        ad_in = 16'h5555; tick();
        ad_in = 16'h6666; tick();
        model[12'h200] = 16'h5555;
        model[12'h201] = 16'h6666;
        reset = 1'b1; ad_in = 16'h7777;
        tick();
        reset = 1'b0; ad_in = 16'h0000;
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_done", {15'd0, burst_done}, 16'd0);
        check("abort_oe", {15'd0, ad_oe}, 16'd0);
        tick();
        rd_burst(16'h0200, 1'b0);
        check("abort_keep_202", model[12'h202], 16'h3333);

        // start poked mid-read must be ignored; back-to-back start follows done
        rd_burst(16'h0100, 1'b1);
        rd_burst(16'h0200, 1'b0);
        tick();
        check("single_done", {15'd0, burst_done}, 16'd0);
        check("idle_busy", {15'd0, busy}, 16'd0);

        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(1, 0) == 1 && wr_addrs.size() > 0) begin
                rd_burst(wr_addrs[$urandom_range(wr_addrs.size() - 1, 0)], 1'b0);
            end else begin
                addr = {4'h0, 12'($urandom_range(4095, 0))};
                for (int k = 0; k < 4; k++) d[k] = 16'($urandom);
                wr_burst(addr, d);
            end
            if ($urandom_range(1, 0) == 1) tick();
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
